// File: rtl/vme_regbank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vme_regbank_pkg: limits, parameter checks and address decode for the |
// | VME register bank.                   Revision: 1.0                    |
// +----------------------------------------------------------------------+
package vme_regbank_pkg;

  localparam int MAX_RW         = 16;
  localparam int MAX_RO         = 16;
  localparam int MAX_REG_WIDTH  = 32;
  localparam int MAX_ADDR_WIDTH = 30;
  localparam int DEF_REG_WIDTH  = 16;
  localparam int IDX_W          = 5;

  typedef enum logic [1:0] {
    KIND_RW   = 2'd0,
    KIND_RO   = 2'd1,
    KIND_NONE = 2'd2
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e        kind;
    logic [IDX_W-1:0] index;
  } reg_sel_t;

  function automatic bit params_ok(input int nrw, input int nro, input int rw, input int aw);
    return (nrw >= 1) && (nrw <= MAX_RW) &&
           (nro >= 0) && (nro <= MAX_RO) &&
           (rw >= 1) && (rw <= MAX_REG_WIDTH) &&
           (aw >= 1) && (aw <= MAX_ADDR_WIDTH) &&
           ((nrw + nro) <= (1 << aw));
  endfunction

  // RW registers occupy the lowest words, RO registers follow directly.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr, input int num_rw, input int num_ro);
    reg_sel_t    sel;
    logic [31:0] off;
    sel.kind  = KIND_NONE;
    sel.index = '0;
    off       = addr - 32'(num_rw);
    if (addr < 32'(num_rw)) begin
      sel.kind  = KIND_RW;
      sel.index = IDX_W'(addr);
    end else if (off < 32'(num_ro)) begin
      sel.kind  = KIND_RO;
      sel.index = IDX_W'(off);
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vme_regbank_sticky.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vme_regbank_sticky: accumulating status register, cleared on read.   |
// |                                      Revision: 1.0                    |
// +----------------------------------------------------------------------+
module vme_regbank_sticky
  import vme_regbank_pkg::*;
#(
  parameter int WIDTH = DEF_REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_set,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_value
);

  logic [WIDTH-1:0] r_value;

  // Bits arriving in the clearing cycle are OR-ed after the clear so none are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else begin
      r_value <= (i_clr ? '0 : r_value) | i_set;
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/vme_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vme_regbank: VME-mapped bank of read/write control registers and     |
// | read-only (optionally sticky) status registers. Revision: 1.0         |
// +----------------------------------------------------------------------+
module vme_regbank
  import vme_regbank_pkg::*;
#(
  parameter int NUM_RW     = 2,
  parameter int NUM_RO     = 2,
  parameter int REG_WIDTH  = 16,
  parameter int ADDR_WIDTH = 18,
  parameter logic [NUM_RW*REG_WIDTH-1:0]            RW_RESET    = '0,
  parameter logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0] STICKY_MASK = '0
) (
  input  logic                                              Clk,
  input  logic                                              Rst_n,
  input  logic [ADDR_WIDTH-1:0]                             VMEAddr,
  input  logic [31:0]                                       VMEWrData,
  output logic [31:0]                                       VMERdData,
  input  logic                                              VMERdMem,
  input  logic                                              VMEWrMem,
  output logic                                              VMERdDone,
  output logic                                              VMEWrDone,
  output logic                                              VMERdError,
  output logic                                              VMEWrError,
  output logic [NUM_RW*REG_WIDTH-1:0]                       rw_o,
  output logic [NUM_RW-1:0]                                 wr_strobe_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*REG_WIDTH-1:0]  ro_i
);

  localparam int RO_N = (NUM_RO > 0) ? NUM_RO : 1;

  if (!params_ok(NUM_RW, NUM_RO, REG_WIDTH, ADDR_WIDTH)) begin : g_bad_params
    $error("vme_regbank: parameter out of range");
  end

  // ---------------- write path ----------------
  logic                        r_wr_d0;
  logic [ADDR_WIDTH-1:0]       r_wr_addr_d0;
  logic [REG_WIDTH-1:0]        r_wr_data_d0;
  logic                        r_wr_d1;
  logic [IDX_W-1:0]            r_wr_idx_d1;
  logic [REG_WIDTH-1:0]        r_wr_data_d1;
  logic [NUM_RW*REG_WIDTH-1:0] r_rw;
  logic [NUM_RW-1:0]           r_strobe;
  logic                        r_wr_done;
  logic                        r_wr_err;
  reg_sel_t                    w_wr_sel;
  logic                        w_wr_accept;
  logic                        w_unused;

  assign w_wr_sel    = decode_addr(32'(r_wr_addr_d0), NUM_RW, NUM_RO);
  // A new write is dropped while the previous one is still in d0 or d1.
  assign w_wr_accept = VMEWrMem && !r_wr_d0 && !r_wr_d1;
  assign w_unused    = ^VMEWrData;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_d0      <= 1'b0;
      r_wr_addr_d0 <= '0;
      r_wr_data_d0 <= '0;
      r_wr_d1      <= 1'b0;
      r_wr_idx_d1  <= '0;
      r_wr_data_d1 <= '0;
      r_rw         <= RW_RESET;
      r_strobe     <= '0;
      r_wr_done    <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_wr_d0 <= w_wr_accept;
      if (w_wr_accept) begin
        r_wr_addr_d0 <= VMEAddr;
        r_wr_data_d0 <= VMEWrData[REG_WIDTH-1:0];
      end
      r_wr_d1 <= r_wr_d0 && (w_wr_sel.kind == KIND_RW);
      if (r_wr_d0) begin
        r_wr_idx_d1  <= w_wr_sel.index;
        r_wr_data_d1 <= r_wr_data_d0;
      end
      r_wr_done <= r_wr_d1 || (r_wr_d0 && (w_wr_sel.kind != KIND_RW));
      r_wr_err  <= r_wr_d0 && (w_wr_sel.kind != KIND_RW);
      for (int i = 0; i < NUM_RW; i++) begin
        r_strobe[i] <= r_wr_d1 && (r_wr_idx_d1 == IDX_W'(i));
        if (r_wr_d1 && (r_wr_idx_d1 == IDX_W'(i))) begin
          r_rw[i*REG_WIDTH +: REG_WIDTH] <= r_wr_data_d1;
        end
      end
    end
  end

  // ---------------- read path ----------------
  logic                  r_rd_d0;
  logic [ADDR_WIDTH-1:0] r_rd_addr_d0;
  logic [31:0]           r_rd_data;
  logic                  r_rd_done;
  logic                  r_rd_err;
  reg_sel_t              w_rd_sel;
  logic [REG_WIDTH-1:0]  w_rd_val;
  logic [REG_WIDTH-1:0]  w_ro_val [RO_N];

  assign w_rd_sel = decode_addr(32'(r_rd_addr_d0), NUM_RW, NUM_RO);

  for (genvar j = 0; j < NUM_RO; j++) begin : g_ro
    if (STICKY_MASK[j]) begin : g_sticky
      logic w_clr;
      assign w_clr = r_rd_d0 && (w_rd_sel.kind == KIND_RO) && (w_rd_sel.index == IDX_W'(j));
      vme_regbank_sticky #(
        .WIDTH (REG_WIDTH)
      ) u_sticky (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_set   (ro_i[j*REG_WIDTH +: REG_WIDTH]),
        .i_clr   (w_clr),
        .o_value (w_ro_val[j])
      );
    end else begin : g_live
      // Holds the value seen at the request edge, returned one edge later.
      logic [REG_WIDTH-1:0] r_sample;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          r_sample <= '0;
        end else begin
          r_sample <= ro_i[j*REG_WIDTH +: REG_WIDTH];
        end
      end
      assign w_ro_val[j] = r_sample;
    end
  end

  if (NUM_RO == 0) begin : g_no_ro
    logic w_unused_ro;
    assign w_ro_val[0] = '0;
    assign w_unused_ro = ^{ro_i, STICKY_MASK};
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if ((w_rd_sel.kind == KIND_RW) && (w_rd_sel.index == IDX_W'(i))) begin
        w_rd_val = r_rw[i*REG_WIDTH +: REG_WIDTH];
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if ((w_rd_sel.kind == KIND_RO) && (w_rd_sel.index == IDX_W'(j))) begin
        w_rd_val = w_ro_val[j];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_d0      <= 1'b0;
      r_rd_addr_d0 <= '0;
      r_rd_data    <= '0;
      r_rd_done    <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      r_rd_d0 <= VMERdMem;
      if (VMERdMem) begin
        r_rd_addr_d0 <= VMEAddr;
      end
      r_rd_done <= r_rd_d0;
      r_rd_err  <= r_rd_d0 && (w_rd_sel.kind == KIND_NONE);
      r_rd_data <= r_rd_d0 ? 32'(w_rd_val) : '0;
    end
  end

  assign rw_o        = r_rw;
  assign wr_strobe_o = r_strobe;
  assign VMEWrDone   = r_wr_done;
  assign VMEWrError  = r_wr_err;
  assign VMERdDone   = r_rd_done;
  assign VMERdError  = r_rd_err;
  assign VMERdData   = r_rd_data;

endmodule
`default_nettype wire
